icache_miss_ctrl: RTL and testbench
===================================

ICACHE_MISS_CTRL -- requirements
Module: icache_miss_ctrl

Interface
REQ-001 SHALL have parameter N, 2, number of miss-request ports from the instruction cache.
REQ-002 SHALL have parameter NUM_MSHR, 4, number of outstanding-miss entries.
REQ-003 SHALL have port clock  in  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high; it clears all state immediately.
REQ-005 SHALL have port miss_valid  in  N  request valid per port.
REQ-006 SHALL have port miss_addr  in  N x 32 (ADDR)  miss address; bits [2:0] are ignored (8-byte block).
REQ-007 SHALL have port miss_ready  out  N  request accepted this cycle; combinational.
REQ-008 SHALL have port proc2Imem_command  out  MEM_COMMAND  MEM_LOAD when issuing, else MEM_NONE.
REQ-009 SHALL have port proc2Imem_addr  out  32  block-aligned issue address; 0 when not issuing.
REQ-010 SHALL have port Imem2proc_transaction_tag  in  4 (MEM_TAG)  nonzero means the issue was accepted under that tag.
REQ-011 SHALL have port Imem2proc_data  in  64 (MEM_BLOCK)  returning block.
REQ-012 SHALL have port Imem2proc_data_tag  in  4 (MEM_TAG)  tag of the returning block; 0 means none.
REQ-013 SHALL have port fill_valid  out  1  fill to the cache this cycle.
REQ-014 SHALL have port fill_addr  out  32  block-aligned fill address.
REQ-015 SHALL have port fill_data  out  64  fill block.
REQ-016 SHALL have port mshr_full  out  1  no FREE entry, taken from registered state.

Function
REQ-017 Each entry SHALL hold a state (FREE, WAIT_ISSUE, or WAIT_DATA), a 29-bit block address, and a 4-bit tag.
REQ-018 Accept order SHALL be port 0 first, then port 1, and so on up to port N-1, all within one cycle.
REQ-019 A valid request whose block matches a non-FREE entry, or a lower-numbered request accepted in the same cycle, SHALL be merged: miss_ready=1 and no allocation.
REQ-020 Otherwise, the request SHALL allocate the lowest-index FREE entry (FREE to WAIT_ISSUE at the edge) with miss_ready=1; if no entry is free, miss_ready=0.
REQ-021 Entries freed in the current cycle SHALL NOT be allocatable until the next cycle.
REQ-022 Issue SHALL select one WAIT_ISSUE entry per cycle, round-robin from rr_ptr; a newly allocated entry is eligible starting the cycle after allocation.
REQ-023 Issue outputs SHALL be combinational in the same cycle: MEM_LOAD with {addr[31:3], 3'b0}.
REQ-024 If Imem2proc_transaction_tag is nonzero in the issue cycle, the entry SHALL move to WAIT_DATA, store the tag, and rr_ptr SHALL advance past the entry; if the tag is zero, the state and rr_ptr SHALL be unchanged and the issue retried the next cycle.
REQ-025 If Imem2proc_data_tag is nonzero and matches the tag of a WAIT_DATA entry, then in the same cycle fill_valid=1, fill_addr=entry address, fill_data=Imem2proc_data, and the entry SHALL become FREE at the edge.
REQ-026 A data tag of zero, or one that matches no entry, SHALL produce fill_valid=0 and no state change.
REQ-027 A request matching an entry being filled this cycle SHALL be merged (the cache captures the fill).
REQ-028 In the same cycle, return SHALL be resolved before issue, so a returning tag that equals a newly granted tag updates only the issued entry.
REQ-029 When not filling, fill_addr and fill_data SHALL be 0.
REQ-030 Throughput SHALL be at most one issue, at most one fill, and at most N accepts per cycle.

Reset
REQ-031 On reset, all entries SHALL be FREE with tag 0, and rr_ptr SHALL be 0.
REQ-032 While reset is high: miss_ready=0, proc2Imem_command=MEM_NONE, proc2Imem_addr=0, fill_valid=0, fill_addr=0, fill_data=0, mshr_full=0.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight entries; later data returns bearing old tags SHALL be ignored per REQ-026.

Configuration
REQ-034 The macro ICACHE_MISS_MERGE_EN SHALL control merging.
REQ-035 With ICACHE_MISS_MERGE_EN defined, behaviour SHALL be as REQ-019 and REQ-027.
REQ-036 Without ICACHE_MISS_MERGE_EN, any request matching a non-FREE entry or a lower accepted port SHALL get miss_ready=0 until that entry frees (no duplicate entries, no merge).

Verification
REQ-037 Single miss: port0 requests 0x1004 at cycle 0 -> miss_ready[0]=1; cycle 1 MEM_LOAD at 0x1000 with tag 3 -> WAIT_DATA; data_tag=3 with data 0xDEAD -> fill_valid=1, fill_addr=0x1000, fill_data=0xDEAD, entry FREE.
REQ-038 Same-cycle duplicate: ports 0 and 1 both request 0x2000 -> miss_ready=2'b11, one entry allocated, exactly one MEM_LOAD issued; without ICACHE_MISS_MERGE_EN -> miss_ready=2'b01.
REQ-039 Full: allocate 4 distinct blocks, then request 0x5000 -> miss_ready=0, mshr_full=1; return one tag -> next cycle 0x5000 is accepted.
REQ-040 Memory refusal: transaction_tag=0 for 3 cycles -> MEM_LOAD 0x1000 repeats each cycle, rr_ptr is unchanged; tag 5 on the 4th cycle -> WAIT_DATA.
REQ-041 Out-of-order return: issue A (tag 1) and B (tag 2), return tag 2 first -> fill_addr=B, and A remains WAIT_DATA; stray tag 7 -> fill_valid=0.
REQ-042 Reset mid-flight: two entries in WAIT_DATA, assert reset -> outputs are 0 immediately; after release, return tag 1 -> fill_valid=0.

Source files
------------

// File: rtl/icache_miss_ctrl.sv
// icache_miss_ctrl: miss-status holding registers between the instruction
// cache and memory. Accepts up to N block misses per cycle, issues one load
// per cycle round-robin over waiting entries, and matches returning memory
// tags to produce cache fills.
//
// Ports:
//   clock, reset                      - rising-edge clock, async active-high reset
//   miss_valid[N], miss_addr[N*32]    - miss requests (port p at bits p*32 +: 32)
//   miss_ready[N]                     - request accepted this cycle (combinational)
//   proc2Imem_command/addr            - load issue to memory (combinational)
//   Imem2proc_transaction_tag         - nonzero: issue accepted under that tag
//   Imem2proc_data/data_tag           - returning block and its tag (0 = none)
//   fill_valid/addr/data              - fill to the cache (combinational)
//   mshr_full                         - no FREE entry in registered state
//
// Build option: define ICACHE_MISS_MERGE_EN to merge requests that hit an
// outstanding block; otherwise such requests are stalled until the entry frees.
module icache_miss_ctrl #(
  parameter int unsigned N        = 2,
  parameter int unsigned NUM_MSHR = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N-1:0]      miss_valid,
  input  logic [N*32-1:0]   miss_addr,
  output logic [N-1:0]      miss_ready,
  output logic [1:0]        proc2Imem_command,
  output logic [31:0]       proc2Imem_addr,
  input  logic [3:0]        Imem2proc_transaction_tag,
  input  logic [63:0]       Imem2proc_data,
  input  logic [3:0]        Imem2proc_data_tag,
  output logic              fill_valid,
  output logic [31:0]       fill_addr,
  output logic [63:0]       fill_data,
  output logic              mshr_full
);

  localparam int unsigned PW = (NUM_MSHR > 1) ? $clog2(NUM_MSHR) : 1;

  typedef enum logic [1:0] {
    MEM_NONE = 2'h0,
    MEM_LOAD = 2'h1
  } mem_cmd_e;

  typedef enum logic [1:0] {
    FREE,
    WAIT_ISSUE,
    WAIT_DATA
  } ent_st_e;

  ent_st_e        st_q   [NUM_MSHR];
  logic [28:0]    addr_q [NUM_MSHR];
  logic [3:0]     tag_q  [NUM_MSHR];
  logic [PW-1:0]  rr_q;

  logic           fill_hit;
  logic [PW-1:0]  fill_idx;
  logic           iss_hit;
  logic [PW-1:0]  iss_idx;
  logic [PW-1:0]  rr_nxt;
  logic           issue_go;
  logic           all_busy;

  logic [28:0]    blk       [N];
  logic [N-1:0]   ready_c;
  logic [N-1:0]   alloc_en;
  logic [PW-1:0]  alloc_idx [N];
  logic [NUM_MSHR-1:0] alloc_mask;
  logic           addr_lsb_unused;

  always_comb begin
    addr_lsb_unused = 1'b0;
    for (int unsigned p = 0; p < N; p++) begin
      blk[p]          = miss_addr[p*32+3 +: 29];
      addr_lsb_unused = addr_lsb_unused ^ (^miss_addr[p*32 +: 3]);
    end
  end

  // Return lookup only considers WAIT_DATA entries, so a tag granted this
  // cycle to an issuing entry can never be matched by the same-cycle return.
  always_comb begin
    fill_hit = 1'b0;
    fill_idx = '0;
    for (int unsigned i = 0; i < NUM_MSHR; i++) begin
      if (!fill_hit && Imem2proc_data_tag != '0 &&
          st_q[i] == WAIT_DATA && tag_q[i] == Imem2proc_data_tag) begin
        fill_hit = 1'b1;
        fill_idx = PW'(i);
      end
    end
  end

  always_comb begin
    logic [PW-1:0] cand;
    cand    = '0;
    iss_hit = 1'b0;
    iss_idx = '0;
    for (int unsigned k = 0; k < NUM_MSHR; k++) begin
      cand = PW'((32'(rr_q) + k) % NUM_MSHR);
      if (!iss_hit && st_q[cand] == WAIT_ISSUE) begin
        iss_hit = 1'b1;
        iss_idx = cand;
      end
    end
    rr_nxt   = PW'((32'(iss_idx) + 32'd1) % NUM_MSHR);
    issue_go = iss_hit && (Imem2proc_transaction_tag != '0);
  end

  // Allocation looks only at registered FREE state, so an entry freed by
  // this cycle's fill is not reused until the next cycle.
  always_comb begin
    logic dup;
    logic got;
    dup        = 1'b0;
    got        = 1'b0;
    ready_c    = '0;
    alloc_en   = '0;
    alloc_mask = '0;
    for (int unsigned p = 0; p < N; p++) begin
      alloc_idx[p] = '0;
    end
    for (int unsigned p = 0; p < N; p++) begin
      dup = 1'b0;
      got = 1'b0;
      if (miss_valid[p]) begin
        for (int unsigned i = 0; i < NUM_MSHR; i++) begin
          if (st_q[i] != FREE && addr_q[i] == blk[p]) dup = 1'b1;
        end
        for (int unsigned q = 0; q < N; q++) begin
          if (q < p && ready_c[q] && blk[q] == blk[p]) dup = 1'b1;
        end
        if (dup) begin
`ifdef ICACHE_MISS_MERGE_EN
          ready_c[p] = 1'b1;
`else
          ready_c[p] = 1'b0;
`endif
        end else begin
          for (int unsigned i = 0; i < NUM_MSHR; i++) begin
            if (!got && st_q[i] == FREE && !alloc_mask[i]) begin
              got           = 1'b1;
              alloc_mask[i] = 1'b1;
              alloc_idx[p]  = PW'(i);
            end
          end
          ready_c[p]  = got;
          alloc_en[p] = got;
        end
      end
    end
  end

  always_comb begin
    all_busy = 1'b1;
    for (int unsigned i = 0; i < NUM_MSHR; i++) begin
      if (st_q[i] == FREE) all_busy = 1'b0;
    end
  end

  assign miss_ready        = reset ? '0 : ready_c;
  assign proc2Imem_command = (!reset && iss_hit) ? MEM_LOAD : MEM_NONE;
  assign proc2Imem_addr    = (!reset && iss_hit) ? {addr_q[iss_idx], 3'b000} : '0;
  assign fill_valid        = !reset && fill_hit;
  assign fill_addr         = (!reset && fill_hit) ? {addr_q[fill_idx], 3'b000} : '0;
  assign fill_data         = (!reset && fill_hit) ? Imem2proc_data : '0;
  assign mshr_full         = !reset && all_busy;

  // Fill, issue and allocate always target entries in distinct states
  // (WAIT_DATA, WAIT_ISSUE, FREE), so their updates never collide.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_MSHR; i++) begin
        st_q[i]   <= FREE;
        addr_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      rr_q <= '0;
    end else begin
      if (fill_hit) begin
        st_q[fill_idx] <= FREE;
      end
      if (issue_go) begin
        st_q[iss_idx]  <= WAIT_DATA;
        tag_q[iss_idx] <= Imem2proc_transaction_tag;
        rr_q           <= rr_nxt;
      end
      for (int unsigned p = 0; p < N; p++) begin
        if (alloc_en[p]) begin
          st_q[alloc_idx[p]]   <= WAIT_ISSUE;
          addr_q[alloc_idx[p]] <= blk[p];
        end
      end
    end
  end

endmodule

// File: tb/tb_icache_miss_ctrl.sv
module tb_icache_miss_ctrl;

  localparam int N = 2;
  localparam int M = 4;
`ifdef ICACHE_MISS_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  miss_valid;
  logic [N*32-1:0] miss_addr;
  logic [N-1:0]  miss_ready;
  logic [1:0]    proc2Imem_command;
  logic [31:0]   proc2Imem_addr;
  logic [3:0]    ttag;
  logic [63:0]   mdata;
  logic [3:0]    dtag;
  logic          fill_valid;
  logic [31:0]   fill_addr;
  logic [63:0]   fill_data;
  logic          mshr_full;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  icache_miss_ctrl #(.N(N), .NUM_MSHR(M)) dut (
    .clock                     (clock),
    .reset                     (reset),
    .miss_valid                (miss_valid),
    .miss_addr                 (miss_addr),
    .miss_ready                (miss_ready),
    .proc2Imem_command         (proc2Imem_command),
    .proc2Imem_addr            (proc2Imem_addr),
    .Imem2proc_transaction_tag (ttag),
    .Imem2proc_data            (mdata),
    .Imem2proc_data_tag        (dtag),
    .fill_valid                (fill_valid),
    .fill_addr                 (fill_addr),
    .fill_data                 (fill_data),
    .mshr_full                 (mshr_full)
  );

  // Reference model: each slot is idle (0), waiting to be sent (1) or
  // waiting for memory (2); slot index and rotating pointer follow the rules.
  int          m_st [M];
  logic [28:0] m_blk[M];
  logic [3:0]  m_tag[M];
  int          m_rr;
  int          n_st [M];
  logic [28:0] n_blk[M];
  logic [3:0]  n_tag[M];
  int          n_rr;
  int          next_tag = 0;

  logic [N-1:0] e_ready;
  logic [1:0]   e_cmd;
  logic [31:0]  e_maddr;
  logic         e_fv;
  logic [31:0]  e_faddr;
  logic [63:0]  e_fdata;
  logic         e_full;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < M; i++) begin
      m_st[i] = 0; m_blk[i] = '0; m_tag[i] = '0;
    end
    m_rr = 0;
  endtask

  function automatic bit tag_busy(input logic [3:0] t);
    for (int i = 0; i < M; i++) if (m_st[i] == 2 && m_tag[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit model_busy();
    for (int i = 0; i < M; i++) if (m_st[i] != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] free_tag();
    for (int k = 0; k < 15; k++) begin
      next_tag = next_tag % 15 + 1;
      if (!tag_busy(4'(next_tag))) return 4'(next_tag);
    end
    return 4'd1;
  endfunction

  function automatic logic [3:0] stray_tag();
    for (int t = 15; t > 0; t--) if (!tag_busy(4'(t)) && 4'(t) != ttag) return 4'(t);
    return 4'd0;
  endfunction

  function automatic logic [3:0] some_outstanding();
    logic [3:0] q[$];
    for (int i = 0; i < M; i++) if (m_st[i] == 2) q.push_back(m_tag[i]);
    if (q.size() == 0) return 4'd0;
    return q[$urandom % q.size()];
  endfunction

  task automatic predict();
    logic [28:0] acc[$];
    bit used[M];
    bit hit, got, found;
    logic [28:0] b;
    int idx;
    n_st = m_st; n_blk = m_blk; n_tag = m_tag; n_rr = m_rr;
    for (int i = 0; i < M; i++) used[i] = 1'b0;
    e_full = 1'b1;
    for (int i = 0; i < M; i++) if (m_st[i] == 0) e_full = 1'b0;
    e_fv = 1'b0; e_faddr = '0; e_fdata = '0;
    if (dtag != 0) begin
      for (int i = 0; i < M; i++) begin
        if (!e_fv && m_st[i] == 2 && m_tag[i] == dtag) begin
          e_fv = 1'b1; e_faddr = {m_blk[i], 3'b000}; e_fdata = mdata; n_st[i] = 0;
        end
      end
    end
    e_cmd = 2'd0; e_maddr = '0; found = 1'b0;
    for (int k = 0; k < M; k++) begin
      idx = (m_rr + k) % M;
      if (!found && m_st[idx] == 1) begin
        found = 1'b1; e_cmd = 2'd1; e_maddr = {m_blk[idx], 3'b000};
        if (ttag != 0) begin
          n_st[idx] = 2; n_tag[idx] = ttag; n_rr = (idx + 1) % M;
        end
      end
    end
    e_ready = '0;
    for (int p = 0; p < N; p++) begin
      if (miss_valid[p]) begin
        b = miss_addr[p*32+3 +: 29];
        hit = 1'b0;
        for (int i = 0; i < M; i++) if (m_st[i] != 0 && m_blk[i] == b) hit = 1'b1;
        foreach (acc[j]) if (acc[j] == b) hit = 1'b1;
        if (hit) e_ready[p] = MERGE;
        else begin
          got = 1'b0;
          for (int i = 0; i < M; i++) begin
            if (!got && m_st[i] == 0 && !used[i]) begin
              got = 1'b1; used[i] = 1'b1; n_st[i] = 1; n_blk[i] = b;
            end
          end
          e_ready[p] = got;
          if (got) acc.push_back(b);
        end
      end
    end
  endtask

  task automatic idle();
    miss_valid = '0; miss_addr = '0; ttag = '0; dtag = '0; mdata = '0;
  endtask

  // Inputs are applied just after a rising edge; outputs sampled mid-cycle.
  task automatic eval();
    predict();
    #4;
    check("ready",  miss_ready,        e_ready);
    check("cmd",    proc2Imem_command, e_cmd);
    check("maddr",  proc2Imem_addr,    e_maddr);
    check("fvalid", fill_valid,        e_fv);
    check("faddr",  fill_addr,         e_faddr);
    check("fdata",  fill_data,         e_fdata);
    check("full",   mshr_full,         e_full);
  endtask

  task automatic tick();
    @(posedge clock);
    m_st = n_st; m_blk = n_blk; m_tag = n_tag; m_rr = n_rr;
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (model_busy() && n < 60) begin
      idle();
      ttag = free_tag();
      dtag = some_outstanding();
      mdata = {$urandom, $urandom};
      eval();
      tick();
      n++;
    end
    check("drain_bound", model_busy(), 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, miss_ready,        '0);
    check({tag, "_cmd"},   proc2Imem_command, '0);
    check({tag, "_maddr"}, proc2Imem_addr,    '0);
    check({tag, "_fv"},    fill_valid,        '0);
    check({tag, "_faddr"}, fill_addr,         '0);
    check({tag, "_fdata"}, fill_data,         '0);
    check({tag, "_full"},  mshr_full,         '0);
  endtask

  initial begin
    logic [31:0] a_addr, b_addr;
    logic [1:0]  dup_exp;
    idle();
    miss_valid = 2'b11; miss_addr = {32'h2000, 32'h1000};
    #2;
    check_reset_outputs("rst");
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
    idle();

    // single miss
    miss_valid = 2'b01; miss_addr[31:0] = 32'h1004;
    eval(); check("single_ready", miss_ready[0], 1'b1); tick();
    idle(); ttag = 4'd3;
    eval(); check("single_cmd", proc2Imem_command, 2'd1); check("single_addr", proc2Imem_addr, 32'h1000); tick();
    idle();
    eval(); check("single_noreissue", proc2Imem_command, 2'd0); tick();
    idle(); dtag = 4'd3; mdata = 64'hDEAD;
    eval(); check("single_fv", fill_valid, 1'b1); check("single_faddr", fill_addr, 32'h1000);
    check("single_fdata", fill_data, 64'hDEAD); tick();
    idle(); dtag = 4'd3;
    eval(); check("single_freed", fill_valid, 1'b0); tick();

    // same-cycle duplicate
    dup_exp = MERGE ? 2'b11 : 2'b01;
    idle(); miss_valid = 2'b11; miss_addr = {32'h2004, 32'h2000};
    eval(); check("dup_ready", miss_ready, dup_exp); tick();
    idle(); ttag = 4'd4;
    eval(); check("dup_cmd", proc2Imem_command, 2'd1); check("dup_addr", proc2Imem_addr, 32'h2000); tick();
    idle();
    eval(); check("dup_one_issue", proc2Imem_command, 2'd0); tick();
    drain();

    // full
    idle(); miss_valid = 2'b11; miss_addr = {32'h3008, 32'h3000};
    eval(); check("full_alloc01", miss_ready, 2'b11); tick();
    idle(); miss_valid = 2'b11; miss_addr = {32'h3018, 32'h3010}; ttag = free_tag();
    eval(); check("full_alloc23", miss_ready, 2'b11); tick();
    for (int c = 0; c < 3; c++) begin
      idle(); miss_valid = 2'b01; miss_addr[31:0] = 32'h5000; ttag = free_tag();
      eval(); check("full_reject", miss_ready[0], 1'b0); check("full_flag", mshr_full, 1'b1); tick();
    end
    idle(); miss_valid = 2'b01; miss_addr[31:0] = 32'h5000; dtag = some_outstanding(); mdata = 64'h55;
    eval(); check("full_fill", fill_valid, 1'b1); check("full_freed_not_alloc", miss_ready[0], 1'b0); tick();
    idle(); miss_valid = 2'b01; miss_addr[31:0] = 32'h5000;
    eval(); check("full_accept_next", miss_ready[0], 1'b1); check("full_clear", mshr_full, 1'b0); tick();
    drain();

    // memory refusal
    idle(); miss_valid = 2'b01; miss_addr[31:0] = 32'h1000;
    eval(); tick();
    for (int c = 0; c < 3; c++) begin
      idle();
      eval(); check("refuse_cmd", proc2Imem_command, 2'd1); check("refuse_addr", proc2Imem_addr, 32'h1000); tick();
    end
    idle(); ttag = 4'd5;
    eval(); check("refuse_accept_addr", proc2Imem_addr, 32'h1000); tick();
    idle();
    eval(); check("refuse_done", proc2Imem_command, 2'd0); tick();
    drain();

    // out-of-order return
    idle(); miss_valid = 2'b11; miss_addr = {32'h4100, 32'h4000};
    eval(); tick();
    idle(); ttag = 4'd1;
    eval(); a_addr = e_maddr; tick();
    idle(); ttag = 4'd2;
    eval(); b_addr = e_maddr; check("ooo_distinct", a_addr == b_addr, 1'b0); tick();
    idle(); dtag = 4'd2; mdata = 64'hB0B0;
    eval(); check("ooo_fv", fill_valid, 1'b1); check("ooo_faddr_b", fill_addr, b_addr); tick();
    idle(); dtag = 4'd7;
    eval(); check("ooo_stray", fill_valid, 1'b0); tick();
    idle(); dtag = 4'd1; mdata = 64'hA0A0;
    eval(); check("ooo_faddr_a", fill_addr, a_addr); tick();

    // reset mid-flight
    idle(); miss_valid = 2'b11; miss_addr = {32'h6008, 32'h6000};
    eval(); tick();
    idle(); ttag = 4'd1; eval(); tick();
    idle(); ttag = 4'd2; eval(); tick();
    idle(); miss_valid = 2'b11; miss_addr = {32'h6100, 32'h6200}; dtag = 4'd1;
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    @(posedge clock); #1;
    reset = 1'b0;
    idle(); dtag = 4'd1; mdata = 64'h1;
    eval(); check("midrst_stale_tag", fill_valid, 1'b0); tick();

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      int r;
      idle();
      miss_valid = N'($urandom);
      for (int p = 0; p < N; p++) miss_addr[p*32 +: 32] = 32'h7000 + (($urandom % 6) << 3) + ($urandom % 8);
      ttag = ($urandom % 4 == 0) ? 4'd0 : free_tag();
      r = $urandom % 5;
      if (r == 0) dtag = 4'd0;
      else if (r == 1) dtag = stray_tag();
      else dtag = some_outstanding();
      mdata = {$urandom, $urandom};
      eval();
      tick();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
